// File: rtl/ahb_line_master.sv
// AHB-Lite master for L1 misses: single write-through, single uncached read, line fill.
// Latency: grant one cycle after the request, NONSEQ the cycle after; single done at +4, N-beat fill done at +N+4.
// Backpressure: hready=0 freezes the address and data pipeline; hresp=1 in a data phase aborts the transaction.
//
// Ports: clk/rst_n; wt_req/rd_req/line_req with pa/wt_data (held until trans_rdy or bus_error);
//        rd_data, line_data/addr_count/line_write, cache_entry_refill, trans_rdy, bus_error toward the L1;
//        bus_req/bus_ack arbitration; haddr/hwrite/htrans/hburst/hsize/hwdata/hready/hresp/hrdata to AHB.
module ahb_line_master #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 8,
    parameter int LINE_BEATS = 16,
    parameter bit WRAP_EN    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wt_req,
    input  logic                          rd_req,
    input  logic                          line_req,
    input  logic [ADDR_W-1:0]             pa,
    input  logic [DATA_W-1:0]             wt_data,
    output logic [DATA_W-1:0]             rd_data,
    output logic [DATA_W-1:0]             line_data,
    output logic [$clog2(LINE_BEATS)-1:0] addr_count,
    output logic                          line_write,
    output logic                          cache_entry_refill,
    output logic                          trans_rdy,
    output logic                          bus_error,
    output logic                          bus_req,
    input  logic                          bus_ack,
    output logic [ADDR_W-1:0]             haddr,
    output logic                          hwrite,
    output logic [1:0]                    htrans,
    output logic [2:0]                    hburst,
    output logic [2:0]                    hsize,
    output logic [DATA_W-1:0]             hwdata,
    input  logic                          hready,
    input  logic                          hresp,
    input  logic [DATA_W-1:0]             hrdata
);
    localparam int IDX_W  = $clog2(LINE_BEATS);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    // Wrapping bursts only exist in AHB for 4, 8 and 16 beats.
    localparam bit WRAP_EFF = WRAP_EN && (LINE_BEATS == 4 || LINE_BEATS == 8 || LINE_BEATS == 16);
    localparam logic [2:0] HBURST_LINE =
        (LINE_BEATS == 4)  ? (WRAP_EFF ? 3'b010 : 3'b011) :
        (LINE_BEATS == 8)  ? (WRAP_EFF ? 3'b100 : 3'b101) :
        (LINE_BEATS == 16) ? (WRAP_EFF ? 3'b110 : 3'b111) : 3'b001;
    localparam logic [2:0]        HSIZE     = 3'(BYTE_W);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BEATS * (DATA_W / 8) - 1);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_ADDR, S_BURST, S_DATA, S_LAST, S_DONE, S_ERR
    } state_e;
    typedef enum logic [1:0] {K_WR, K_RD, K_LINE} kind_e;

    state_e             state_q;
    kind_e              kind_q;
    logic [IDX_W-1:0]   aidx_q;      // beat index of the current address phase
    logic [IDX_W-1:0]   didx_q;      // beat index of the current data phase
    logic [IDX_W-1:0]   cnt_q;       // address phases still to issue after the current one
    logic [DATA_W-1:0]  rd_data_q, line_data_q, hwdata_q;
    logic [IDX_W-1:0]   addr_count_q;
    logic               line_write_q, refill_q, trans_rdy_q, bus_error_q, bus_req_q, hwrite_q;
    logic [ADDR_W-1:0]  haddr_q;
    logic [1:0]         htrans_q;
    logic [2:0]         hburst_q;

    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   aidx_inc;

    // Fill starts at the requested beat when wrapping, at the line base otherwise.
    assign start_idx = WRAP_EFF ? pa[BYTE_W +: IDX_W] : '0;
    // Increment modulo LINE_BEATS gives the wrap inside the aligned line for free.
    assign aidx_inc  = aidx_q + IDX_W'(1);

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [IDX_W-1:0]  idx);
        return (a & ~LINE_MASK) | (ADDR_W'(idx) << BYTE_W);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            kind_q       <= K_WR;
            aidx_q       <= '0;
            didx_q       <= '0;
            cnt_q        <= '0;
            rd_data_q    <= '0;
            line_data_q  <= '0;
            hwdata_q     <= '0;
            addr_count_q <= '0;
            line_write_q <= 1'b0;
            refill_q     <= 1'b0;
            trans_rdy_q  <= 1'b0;
            bus_error_q  <= 1'b0;
            bus_req_q    <= 1'b0;
            hwrite_q     <= 1'b0;
            haddr_q      <= '0;
            htrans_q     <= HT_IDLE;
            hburst_q     <= 3'b000;
        end else begin
            line_write_q <= 1'b0;
            refill_q     <= 1'b0;
            trans_rdy_q  <= 1'b0;
            bus_error_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wt_req) begin
                        kind_q <= K_WR;   state_q <= S_ARB; bus_req_q <= 1'b1;
                    end else if (rd_req) begin
                        kind_q <= K_RD;   state_q <= S_ARB; bus_req_q <= 1'b1;
                    end else if (line_req) begin
                        kind_q <= K_LINE; state_q <= S_ARB; bus_req_q <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (bus_ack) begin
                        state_q  <= S_ADDR;
                        htrans_q <= HT_NONSEQ;
                        hwrite_q <= (kind_q == K_WR);
                        aidx_q   <= start_idx;
                        if (kind_q == K_LINE) begin
                            haddr_q  <= beat_addr(pa, start_idx);
                            hburst_q <= HBURST_LINE;
                            cnt_q    <= IDX_W'(LINE_BEATS - 1);
                        end else begin
                            haddr_q  <= pa;
                            hburst_q <= 3'b000;
                            cnt_q    <= '0;
                        end
                    end
                end
                // ADDR has no data phase in flight; BURST and DATA each carry one.
                S_ADDR, S_BURST, S_DATA: begin
                    if (state_q != S_ADDR && hresp) begin
                        state_q     <= S_ERR;
                        htrans_q    <= HT_IDLE;
                        hwrite_q    <= 1'b0;
                        hburst_q    <= 3'b000;
                        bus_req_q   <= 1'b0;
                        bus_error_q <= 1'b1;
                    end else if (hready) begin
                        if (state_q != S_ADDR && kind_q == K_LINE) begin
                            line_write_q <= 1'b1;
                            line_data_q  <= hrdata;
                            addr_count_q <= didx_q;
                        end
                        if (state_q == S_DATA) begin
                            bus_req_q <= 1'b0;
                            if (kind_q == K_LINE) begin
                                state_q <= S_LAST;
                            end else begin
                                state_q     <= S_DONE;
                                trans_rdy_q <= 1'b1;
                                if (kind_q == K_RD) rd_data_q <= hrdata;
                            end
                        end else begin
                            didx_q <= aidx_q;
                            if (kind_q == K_WR) hwdata_q <= wt_data;
                            if (cnt_q != '0) begin
                                state_q  <= S_BURST;
                                htrans_q <= HT_SEQ;
                                aidx_q   <= aidx_inc;
                                haddr_q  <= beat_addr(pa, aidx_inc);
                                cnt_q    <= cnt_q - IDX_W'(1);
                            end else begin
                                state_q  <= S_DATA;
                                htrans_q <= HT_IDLE;
                                hwrite_q <= 1'b0;
                                hburst_q <= 3'b000;
                            end
                        end
                    end
                end
                // One spare cycle so the refill pulse trails the final line_write.
                S_LAST: begin
                    state_q     <= S_DONE;
                    trans_rdy_q <= 1'b1;
                    refill_q    <= 1'b1;
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    hwdata_q <= '0;
                end
                S_ERR: begin
                    state_q  <= S_IDLE;
                    hwdata_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_data            = rd_data_q;
    assign line_data          = line_data_q;
    assign addr_count         = addr_count_q;
    assign line_write         = line_write_q;
    assign cache_entry_refill = refill_q;
    assign trans_rdy          = trans_rdy_q;
    assign bus_error          = bus_error_q;
    assign bus_req            = bus_req_q;
    assign haddr              = haddr_q;
    assign hwrite             = hwrite_q;
    assign htrans             = htrans_q;
    assign hburst             = hburst_q;
    assign hsize              = HSIZE;
    assign hwdata             = hwdata_q;
endmodule

// File: tb/tb_ahb_line_master.sv
// Directed bench for ahb_line_master: two instances (4-beat wrapping, 16-beat incrementing)
// share one slave model; expected addresses, beats and read data are queued when a request
// is driven and consumed as the selected instance produces them.
module tb_ahb_line_master;
    localparam int AW = 24;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] pa;
    logic [DW-1:0] wt_data, hrdata;
    logic          bus_ack, hready, hresp;
    logic          a_wt, a_rd, a_line, b_wt, b_rd, b_line;

    logic [DW-1:0] a_rd_data, a_line_data, a_hwdata, b_rd_data, b_line_data, b_hwdata;
    logic [1:0]    a_addr_count;
    logic [3:0]    b_addr_count;
    logic          a_line_write, a_refill, a_trans_rdy, a_bus_error, a_bus_req, a_hwrite;
    logic          b_line_write, b_refill, b_trans_rdy, b_bus_error, b_bus_req, b_hwrite;
    logic [AW-1:0] a_haddr, b_haddr;
    logic [1:0]    a_htrans, b_htrans;
    logic [2:0]    a_hburst, b_hburst, a_hsize, b_hsize;

    ahb_line_master #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(4), .WRAP_EN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .wt_req(a_wt), .rd_req(a_rd), .line_req(a_line),
        .pa(pa), .wt_data(wt_data), .rd_data(a_rd_data), .line_data(a_line_data),
        .addr_count(a_addr_count), .line_write(a_line_write), .cache_entry_refill(a_refill),
        .trans_rdy(a_trans_rdy), .bus_error(a_bus_error), .bus_req(a_bus_req), .bus_ack(bus_ack),
        .haddr(a_haddr), .hwrite(a_hwrite), .htrans(a_htrans), .hburst(a_hburst), .hsize(a_hsize),
        .hwdata(a_hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata));

    ahb_line_master #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(16), .WRAP_EN(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .wt_req(b_wt), .rd_req(b_rd), .line_req(b_line),
        .pa(pa), .wt_data(wt_data), .rd_data(b_rd_data), .line_data(b_line_data),
        .addr_count(b_addr_count), .line_write(b_line_write), .cache_entry_refill(b_refill),
        .trans_rdy(b_trans_rdy), .bus_error(b_bus_error), .bus_req(b_bus_req), .bus_ack(bus_ack),
        .haddr(b_haddr), .hwrite(b_hwrite), .htrans(b_htrans), .hburst(b_hburst), .hsize(b_hsize),
        .hwdata(b_hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata));

    // Selected instance (0 = A, 1 = B) drives the slave model and the monitors.
    logic          sel;
    logic [AW-1:0] s_haddr;
    logic [1:0]    s_htrans;
    logic [2:0]    s_hburst;
    logic [DW-1:0] s_rd_data, s_line_data, s_hwdata;
    logic [3:0]    s_addr_count;
    logic          s_line_write, s_refill, s_trans_rdy, s_bus_error, s_bus_req, s_hwrite;
    assign s_haddr      = sel ? b_haddr      : a_haddr;
    assign s_htrans     = sel ? b_htrans     : a_htrans;
    assign s_hburst     = sel ? b_hburst     : a_hburst;
    assign s_rd_data    = sel ? b_rd_data    : a_rd_data;
    assign s_line_data  = sel ? b_line_data  : a_line_data;
    assign s_hwdata     = sel ? b_hwdata     : a_hwdata;
    assign s_addr_count = sel ? b_addr_count : {2'b00, a_addr_count};
    assign s_line_write = sel ? b_line_write : a_line_write;
    assign s_refill     = sel ? b_refill     : a_refill;
    assign s_trans_rdy  = sel ? b_trans_rdy  : a_trans_rdy;
    assign s_bus_error  = sel ? b_bus_error  : a_bus_error;
    assign s_bus_req    = sel ? b_bus_req    : a_bus_req;
    assign s_hwrite     = sel ? b_hwrite     : a_hwrite;

    logic [60:0] a_all;
    logic [62:0] b_all;
    assign a_all = {a_rd_data, a_line_data, a_addr_count, a_line_write, a_refill, a_trans_rdy,
                    a_bus_error, a_bus_req, a_haddr, a_hwrite, a_htrans, a_hburst, a_hwdata};
    assign b_all = {b_rd_data, b_line_data, b_addr_count, b_line_write, b_refill, b_trans_rdy,
                    b_bus_error, b_bus_req, b_haddr, b_hwrite, b_htrans, b_hburst, b_hwdata};

    // Slave: read data is a fixed function of the accepted address.
    logic [AW-1:0] dph_addr = '0;
    always @(posedge clk) if (s_htrans[1] && hready) dph_addr <= s_haddr;
    assign hrdata = dph_addr[7:0] ^ 8'h6E;

    logic [63:0] exp_addr_q[$];
    logic [11:0] exp_beat_q[$];
    logic [7:0]  exp_rd_q[$];

    int checks = 0;
    int errors = 0;
    int n_lw, n_tr, n_rf, n_be, n_arb, n_addr;
    int c_nonseq, c_tr, c_rf, c_be, c_firstlw, c_lastlw;
    logic [2:0] ns_hburst;
    logic       ns_hwrite;
    logic [7:0] dp_hwdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drop_reqs();
        a_wt = 0; a_rd = 0; a_line = 0; b_wt = 0; b_rd = 0; b_line = 0;
    endtask

    // Runs ncyc cycles (cycle 1 = first cycle after the request was driven), driving
    // bus_ack/hready/hresp per the arguments and consuming the scoreboard queues.
    task automatic watch(input int ncyc, input int ack_from, input int hold_at,
                         input int hold_len, input int err_beat, input int rst_at);
        int hold_left, err_c;
        logic [63:0] e;
        hold_left = hold_len; err_c = -1;
        n_lw = 0; n_tr = 0; n_rf = 0; n_be = 0; n_arb = 0; n_addr = 0;
        c_nonseq = -1; c_tr = -1; c_rf = -1; c_be = -1; c_firstlw = -1; c_lastlw = -1;
        ns_hburst = 3'b000; ns_hwrite = 1'b0; dp_hwdata = 8'h00;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            bus_ack = (c >= ack_from);
            hresp   = (c == err_c);
            if (hold_left > 0 && n_addr == hold_at) begin
                hready = 1'b0; hold_left--;
            end else begin
                hready = 1'b1;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_a_outputs", 64'(a_all), 64'd0);
                check("rst_b_outputs", 64'(b_all), 64'd0);
                drop_reqs();
                return;
            end
            if (s_bus_req && s_htrans == 2'b00 && c_nonseq < 0) n_arb++;
            if (c_nonseq > 0 && c == c_nonseq + 1) dp_hwdata = s_hwdata;
            if (s_htrans == 2'b10 && c_nonseq < 0) begin
                c_nonseq = c; ns_hburst = s_hburst; ns_hwrite = s_hwrite;
            end
            if (s_htrans[1] && !hready) begin
                e = (exp_addr_q.size() > 0) ? exp_addr_q[0] : '1;
                check("hold_haddr", 64'(s_haddr), e);
                check("hold_htrans", 64'(s_htrans), 64'd3);
            end
            if (s_htrans[1] && hready) begin
                n_addr++;
                if (exp_addr_q.size() > 0) e = exp_addr_q.pop_front(); else e = '1;
                check("haddr", 64'(s_haddr), e);
                if (n_addr - 1 == err_beat) err_c = c + 1;
            end
            if (s_line_write) begin
                n_lw++; c_lastlw = c;
                if (c_firstlw < 0) c_firstlw = c;
                if (exp_beat_q.size() > 0) e = 64'(exp_beat_q.pop_front()); else e = '1;
                check("line_beat", 64'({s_addr_count, s_line_data}), e);
            end
            if (s_refill) begin
                n_rf++; c_rf = c;
            end
            if (s_trans_rdy) begin
                n_tr++; c_tr = c;
                if (exp_rd_q.size() > 0) check("rd_data", 64'(s_rd_data), 64'(exp_rd_q.pop_front()));
                drop_reqs();
            end
            if (s_bus_error) begin
                n_be++; c_be = c;
                check("err_htrans", 64'(s_htrans), 64'd0);
                check("err_bus_req", 64'(s_bus_req), 64'd0);
                drop_reqs();
            end
        end
    endtask

    task automatic check_queues_empty();
        check("addr_left", 64'(exp_addr_q.size()), 64'd0);
        check("beat_left", 64'(exp_beat_q.size()), 64'd0);
        check("rd_left",   64'(exp_rd_q.size()),   64'd0);
    endtask

    initial begin
        logic [AW-1:0] a;
        int idx;
        rst_n = 1'b0; pa = '0; wt_data = '0; bus_ack = 1'b0; hready = 1'b1; hresp = 1'b0;
        sel = 1'b0;
        drop_reqs();
        repeat (3) @(negedge clk);
        check("reset_a", 64'(a_all), 64'd0);
        check("reset_b", 64'(b_all), 64'd0);
        check("hsize_a", 64'(a_hsize), 64'd0);
        check("hsize_b", 64'(b_hsize), 64'd0);
        rst_n = 1'b1; bus_ack = 1'b1;
        @(negedge clk);

        // Single uncached read.
        sel = 1'b0; pa = 24'h001234;
        exp_addr_q.push_back(64'h001234);
        exp_rd_q.push_back(8'h5A);
        a_rd = 1'b1;
        watch(8, 1, -1, 0, -1, -1);
        check("rd_nonseq_cyc", 64'(c_nonseq), 64'd2);
        check("rd_hburst", 64'(ns_hburst), 64'd0);
        check("rd_hwrite", 64'(ns_hwrite), 64'd0);
        check("rd_arb_cycles", 64'(n_arb), 64'd1);
        check("rd_trans_rdy_cyc", 64'(c_tr), 64'd4);
        check("rd_trans_rdy_cnt", 64'(n_tr), 64'd1);
        check("rd_no_refill", 64'(n_rf), 64'd0);
        check_queues_empty();

        // 4-beat wrapping fill, critical word first.
        sel = 1'b0; pa = 24'h000106;
        for (int k = 0; k < 4; k++) begin
            idx = (2 + k) % 4;
            a = 24'h000104 + AW'(idx);
            exp_addr_q.push_back(64'(a));
            exp_beat_q.push_back({4'(idx), a[7:0] ^ 8'h6E});
        end
        a_line = 1'b1;
        watch(12, 1, -1, 0, -1, -1);
        check("wrap_hburst", 64'(ns_hburst), 64'b010);
        check("wrap_nonseq_cyc", 64'(c_nonseq), 64'd2);
        check("wrap_lw_cnt", 64'(n_lw), 64'd4);
        check("wrap_first_lw", 64'(c_firstlw), 64'd4);
        check("wrap_last_lw", 64'(c_lastlw), 64'd7);
        check("wrap_trans_rdy_cyc", 64'(c_tr), 64'd8);
        check("wrap_refill_cyc", 64'(c_rf), 64'd8);
        check("wrap_refill_cnt", 64'(n_rf), 64'd1);
        check_queues_empty();

        // 16-beat incrementing fill with a 2-cycle wait state on beat 5.
        sel = 1'b1; pa = 24'h002037;
        for (int k = 0; k < 16; k++) begin
            a = 24'h002030 + AW'(k);
            exp_addr_q.push_back(64'(a));
            exp_beat_q.push_back({4'(k), a[7:0] ^ 8'h6E});
        end
        b_line = 1'b1;
        watch(28, 1, 5, 2, -1, -1);
        check("incr_hburst", 64'(ns_hburst), 64'b111);
        check("incr_lw_cnt", 64'(n_lw), 64'd16);
        check("incr_trans_rdy_cyc", 64'(c_tr), 64'd22);
        check("incr_refill_cnt", 64'(n_rf), 64'd1);
        check_queues_empty();

        // Error response on beat 2 of a 4-beat fill.
        sel = 1'b0; pa = 24'h000200;
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(64'h000200 + 64'(k));
        for (int k = 0; k < 2; k++) exp_beat_q.push_back({4'(k), 8'(k) ^ 8'h6E});
        a_line = 1'b1;
        watch(10, 1, -1, 0, 2, -1);
        check("err_cnt", 64'(n_be), 64'd1);
        check("err_cyc", 64'(c_be), 64'd6);
        check("err_no_trans_rdy", 64'(n_tr), 64'd0);
        check("err_no_refill", 64'(n_rf), 64'd0);
        check("err_lw_cnt", 64'(n_lw), 64'd2);
        check("err_bus_req_after", 64'(a_bus_req), 64'd0);
        check_queues_empty();

        // All three requests at once with a late grant: the write goes first.
        sel = 1'b0; pa = 24'h000310; wt_data = 8'hC3; bus_ack = 1'b0;
        exp_addr_q.push_back(64'h000310);
        a_wt = 1'b1; a_rd = 1'b1; a_line = 1'b1;
        watch(12, 4, -1, 0, -1, -1);
        check("prio_arb_cycles", 64'(n_arb), 64'd4);
        check("prio_nonseq_cyc", 64'(c_nonseq), 64'd5);
        check("prio_hwrite", 64'(ns_hwrite), 64'd1);
        check("prio_hburst", 64'(ns_hburst), 64'd0);
        check("prio_hwdata", 64'(dp_hwdata), 64'hC3);
        check("prio_trans_rdy_cyc", 64'(c_tr), 64'd7);
        check("prio_lw_cnt", 64'(n_lw), 64'd0);
        check_queues_empty();

        // Reset while beat 3 of a 16-beat fill is on the bus, then a clean read.
        sel = 1'b1; pa = 24'h000400;
        for (int k = 0; k < 3; k++) exp_addr_q.push_back(64'h000400 + 64'(k));
        exp_beat_q.push_back({4'd0, 8'h00 ^ 8'h6E});
        b_line = 1'b1;
        watch(10, 1, -1, 0, -1, 5);
        check_queues_empty();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pa = 24'h000456;
        exp_addr_q.push_back(64'h000456);
        exp_rd_q.push_back(8'h56 ^ 8'h6E);
        b_rd = 1'b1;
        watch(8, 1, -1, 0, -1, -1);
        check("post_rst_trans_rdy_cyc", 64'(c_tr), 64'd4);
        check("post_rst_trans_rdy_cnt", 64'(n_tr), 64'd1);
        check_queues_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_line_master.md
Name: ahb_line_master

Overview:
- Parametrised AHB-Lite bus master. Next generation of the CPU-side bus unit that serves L1 cache misses and uncached accesses.
- Adds configurable address width, data width and line length.
- Adds proper 2-bit HTRANS and 3-bit HBURST, with optional wrapping (critical-word-first) line fills.
- Adds explicit bus arbitration and error abort. Sits between the L1 controller and the system AHB fabric.

Parameters:
- ADDR_W, 24: haddr/pa width (24 without MMU, 32 with PAE MMU).
- DATA_W, 8: beat width, one of 8/16/32; hsize = log2(DATA_W/8).
- LINE_BEATS, 16: beats per cache line, power of two, 2..128.
- WRAP_EN, 1: 1 = wrapping line fill starting at the requested beat. Forced to 0 unless LINE_BEATS is 4, 8 or 16.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wt_req  in  1  single write-through request.
- rd_req  in  1  single uncached read request.
- line_req  in  1  line-fill request.
- pa  in  ADDR_W  request address, DATA_W-aligned.
- wt_data  in  DATA_W  write data.
- rd_data  out  DATA_W  single-read result, valid with trans_rdy.
- line_data  out  DATA_W  fill beat, valid with line_write.
- addr_count  out  log2(LINE_BEATS)  line-relative beat index of line_data.
- line_write  out  1  fill beat strobe.
- cache_entry_refill  out  1  line fill complete (pulse with trans_rdy).
- trans_rdy  out  1  transaction done pulse.
- bus_error  out  1  transaction aborted pulse.
- bus_req  out  1  arbitration request.
- bus_ack  in  1  bus grant.
- haddr  out  ADDR_W  AHB address.
- hwrite  out  1  AHB write.
- htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ.
- hburst  out  3  000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16.
- hsize  out  3  constant log2(DATA_W/8).
- hwdata  out  DATA_W  AHB write data.
- hready  in  1  AHB ready.
- hresp  in  1  1 = ERROR.
- hrdata  in  DATA_W  AHB read data.

Behaviour:
- Reset (async, any state): FSM to IDLE. All outputs 0 except hsize, which is constant.
- All outputs are registered.
- Request rules:
  - Requests are sampled only in IDLE.
  - Priority when several are active: wt_req > rd_req > line_req.
  - The requester holds its req, pa and wt_data stable until trans_rdy or bus_error. It drops req in that pulse cycle.
- FSM: IDLE -> ARB -> ADDR -> (BURST) -> DATA -> DONE|ERR -> IDLE.
  - ARB: bus_req=1. Advance when bus_ack=1.
  - ADDR: htrans=NONSEQ.
  - BURST: htrans=SEQ.
  - bus_req stays 1 until the final data phase completes.
- Address/data phases:
  - Pipelined per AHB-Lite. The next address and the current data advance only on hready=1.
  - While hready=0, haddr/htrans/hwdata are held and nothing is sampled.
- Single access: hburst=SINGLE. Write: hwdata=wt_data in the data phase. Read: rd_data captures hrdata.
- Line fill:
  - hburst is the WRAPn code if WRAP_EN=1, the INCRn code for LINE_BEATS 4/8/16, otherwise INCR.
  - WRAP_EN=1: first beat = pa beat offset; the address wraps within the LINE_BEATS*DATA_W/8-byte aligned block.
  - WRAP_EN=0: first beat = line base (pa offset bits cleared).
  - Each accepted beat produces one line_write pulse the following cycle, with line_data and addr_count = that beat's index.
  - cache_entry_refill and trans_rdy pulse together one cycle after the last line_write.
- Latency with bus_ack=1 and hready=1, request first seen in IDLE at cycle 0:
  - ARB at 1, NONSEQ at 2.
  - Single: trans_rdy at 4.
  - 4-beat line: line_write at 4..7, trans_rdy at 8.
- Error: hresp=1 in any data phase:
  - Next cycle htrans=IDLE, remaining beats are dropped, bus_req goes low.
  - bus_error pulses for 1 cycle. No trans_rdy, no cache_entry_refill.
  - line_write pulses already emitted stand; the L1 discards the line.
- bus_ack withdrawn mid-burst: ignored; the burst completes (locked fill).
- DONE/ERR last 1 cycle; a request active in that cycle is not sampled until IDLE.

Test Plan:
- rd_req, pa=0x001234, hrdata=0x5A, hready=1, bus_ack=1 -> NONSEQ/SINGLE at cycle 2, trans_rdy and rd_data=0x5A at cycle 4.
- WRAP_EN=1, LINE_BEATS=4, DATA_W=8, line_req pa=0x000106 -> hburst=010, haddr 106,107,104,105, addr_count 2,3,0,1, trans_rdy with cache_entry_refill after 4th line_write.
- WRAP_EN=0, LINE_BEATS=16, hready low 2 cycles on beat 5 -> haddr/htrans held, exactly 16 line_write pulses, addr_count 0..15, hburst=111.
- hresp=1 on beat 2 of 4-beat fill -> htrans=00 next cycle, bus_error 1 pulse, no trans_rdy, no refill, bus_req=0.
- wt_req, rd_req, line_req raised same cycle with bus_ack delayed 3 cycles -> bus_req held 3 cycles, write (hwrite=1, hwdata=wt_data) issued first.
- rst_n low mid-burst at beat 3 -> all outputs 0 immediately; a fresh rd_req after reset completes normally.
